// File: rtl/frame_serializer_if.sv
// Parallel-load / serial-play handshake bundle for frame_serializer.
interface frame_serializer_if #(parameter int WIDTH = 8);
  logic             load;
  logic [1:0]       count;
  logic [WIDTH-1:0] d0;
  logic [WIDTH-1:0] d1;
  logic [WIDTH-1:0] d2;
  logic             load_ready;
  logic             putFlag;
  logic [WIDTH-1:0] value;
  logic             busy;
  logic             done;

  modport master (
    output load, count, d0, d1, d2,
    input  load_ready, putFlag, value, busy, done
  );

  modport slave (
    input  load, count, d0, d1, d2,
    output load_ready, putFlag, value, busy, done
  );
endinterface

// File: rtl/frame_serializer.sv
// Plays a 1..3 word parallel frame out one word per cycle, then holds putFlag low for GAP_CYCLES.
// Define SERIALIZER_QUEUE_EN to add a one-deep pending-frame buffer accepting loads while busy.
module frame_serializer #(
  parameter int WIDTH      = 8,
  parameter int MAX_WORDS  = 3,
  parameter int GAP_CYCLES = 1
) (
  input  logic                clk,
  input  logic                reset,
  frame_serializer_if.slave   bus
);
  typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

  state_t           state;
  logic [WIDTH-1:0] words [3];
  logic [1:0]       idx;
  logic [1:0]       last_idx;
  logic [3:0]       gap_cnt;

  logic             accept;
  logic             gap_done;
  logic             direct;
  logic             from_pending;
  logic             start;
  logic [1:0]       eff_count;
  logic [1:0]       start_last;
  logic [WIDTH-1:0] start_w [3];

  assign accept   = bus.load && bus.load_ready && (bus.count != '0);
  assign gap_done = (state == GAP) && (gap_cnt == 4'(GAP_CYCLES));
  // A load landing on the final gap cycle launches directly, keeping the gap exact.
  assign direct   = accept && ((state == IDLE) || gap_done);
  assign start    = direct || from_pending;

  always_comb begin
    eff_count = (bus.count > 2'(MAX_WORDS)) ? 2'(MAX_WORDS) : bus.count;
  end

`ifdef SERIALIZER_QUEUE_EN
  logic             pending_valid;
  logic [1:0]       pending_last;
  logic [WIDTH-1:0] pending_w [3];

  assign bus.load_ready = !pending_valid;
  assign from_pending   = gap_done && pending_valid;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending_valid <= 1'b0;
      pending_last  <= '0;
      pending_w     <= '{default: '0};
    end else if (from_pending) begin
      pending_valid <= 1'b0;
    end else if (accept && !direct) begin
      pending_valid <= 1'b1;
      pending_last  <= eff_count - 2'd1;
      pending_w     <= '{bus.d0, bus.d1, bus.d2};
    end
  end
`else
  assign bus.load_ready = (state == IDLE);
  assign from_pending   = 1'b0;
`endif

  always_comb begin
    start_last = eff_count - 2'd1;
    start_w    = '{bus.d0, bus.d1, bus.d2};
`ifdef SERIALIZER_QUEUE_EN
    if (from_pending) begin
      start_last = pending_last;
      start_w    = pending_w;
    end
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      words       <= '{default: '0};
      idx         <= '0;
      last_idx    <= '0;
      gap_cnt     <= '0;
      bus.putFlag <= 1'b0;
      bus.value   <= '0;
      bus.busy    <= 1'b0;
      bus.done    <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      if (start) begin
        state       <= SEND;
        words       <= start_w;
        last_idx    <= start_last;
        idx         <= '0;
        bus.putFlag <= 1'b1;
        bus.value   <= start_w[0];
        bus.busy    <= 1'b1;
      end else begin
        case (state)
          SEND: begin
            if (idx == last_idx) begin
              state       <= GAP;
              bus.putFlag <= 1'b0;
              bus.value   <= '0;
              bus.done    <= 1'b1;
              gap_cnt     <= 4'd1;
            end else begin
              idx       <= idx + 2'd1;
              bus.value <= words[idx + 2'd1];
            end
          end
          GAP: begin
            if (gap_done) begin
              state    <= IDLE;
              bus.busy <= 1'b0;
            end else begin
              gap_cnt <= gap_cnt + 4'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_frame_serializer.sv
// Directed bench for frame_serializer: dut_a uses GAP_CYCLES=1, dut_b uses GAP_CYCLES=4.
module tb_frame_serializer;
  logic clk;
  logic reset;
  int   checks;
  int   failures;

  frame_serializer_if #(.WIDTH(8)) a_if ();
  frame_serializer_if #(.WIDTH(8)) b_if ();

  frame_serializer #(.WIDTH(8), .MAX_WORDS(3), .GAP_CYCLES(1)) dut_a (
    .clk(clk), .reset(reset), .bus(a_if)
  );
  frame_serializer #(.WIDTH(8), .MAX_WORDS(3), .GAP_CYCLES(4)) dut_b (
    .clk(clk), .reset(reset), .bus(b_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic exp_a(input string tag, input logic p, input logic [7:0] v,
                       input logic b, input logic d);
    chk({tag, ".putFlag"}, 32'(a_if.putFlag), 32'(p));
    chk({tag, ".value"},   32'(a_if.value),   32'(v));
    chk({tag, ".busy"},    32'(a_if.busy),    32'(b));
    chk({tag, ".done"},    32'(a_if.done),    32'(d));
  endtask

  task automatic exp_b(input string tag, input logic p, input logic [7:0] v,
                       input logic b, input logic d);
    chk({tag, ".putFlag"}, 32'(b_if.putFlag), 32'(p));
    chk({tag, ".value"},   32'(b_if.value),   32'(v));
    chk({tag, ".busy"},    32'(b_if.busy),    32'(b));
    chk({tag, ".done"},    32'(b_if.done),    32'(d));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_a(input logic [1:0] c, input logic [7:0] x0, input logic [7:0] x1,
                        input logic [7:0] x2);
    a_if.load = 1'b1; a_if.count = c; a_if.d0 = x0; a_if.d1 = x1; a_if.d2 = x2;
  endtask

  initial begin
    checks = 0; failures = 0;
    reset = 1'b1;
    a_if.load = 1'b0; a_if.count = '0; a_if.d0 = '0; a_if.d1 = '0; a_if.d2 = '0;
    b_if.load = 1'b0; b_if.count = '0; b_if.d0 = '0; b_if.d1 = '0; b_if.d2 = '0;
    step(); step();
    exp_a("rst", 1'b0, 8'd0, 1'b0, 1'b0);
    chk("rst.load_ready", 32'(a_if.load_ready), 32'd1);
    reset = 1'b0;
    step();

    // single word frame
    load_a(2'd1, 8'd10, 8'd0, 8'd0);
    step(); a_if.load = 1'b0;
    exp_a("t1.w0", 1'b1, 8'd10, 1'b1, 1'b0);
    step(); exp_a("t1.gap", 1'b0, 8'd0, 1'b1, 1'b1);
    step(); exp_a("t1.idle", 1'b0, 8'd0, 1'b0, 1'b0);
    chk("t1.load_ready", 32'(a_if.load_ready), 32'd1);

    // two word frame
    load_a(2'd2, 8'd20, 8'd30, 8'd0);
    step(); a_if.load = 1'b0;
    exp_a("t2.w0", 1'b1, 8'd20, 1'b1, 1'b0);
    step(); exp_a("t2.w1", 1'b1, 8'd30, 1'b1, 1'b0);
    step(); exp_a("t2.gap", 1'b0, 8'd0, 1'b1, 1'b1);
    step(); exp_a("t2.idle", 1'b0, 8'd0, 1'b0, 1'b0);

    // three words, inputs scrambled after capture
    load_a(2'd3, 8'd40, 8'd50, 8'd60);
    step();
    a_if.load = 1'b0; a_if.d0 = 8'hFF; a_if.d1 = 8'hFF; a_if.d2 = 8'hFF;
    exp_a("t3.w0", 1'b1, 8'd40, 1'b1, 1'b0);
    chk("t3.load_ready_busy", 32'(a_if.load_ready),
`ifdef SERIALIZER_QUEUE_EN
        32'd1);
`else
        32'd0);
`endif
    step(); exp_a("t3.w1", 1'b1, 8'd50, 1'b1, 1'b0);
    step(); exp_a("t3.w2", 1'b1, 8'd60, 1'b1, 1'b0);
    step(); exp_a("t3.gap", 1'b0, 8'd0, 1'b1, 1'b1);
    step(); exp_a("t3.idle", 1'b0, 8'd0, 1'b0, 1'b0);

    // load during SEND of a 3-word frame
    load_a(2'd3, 8'd70, 8'd80, 8'd90);
    step();
    exp_a("t4.w0", 1'b1, 8'd70, 1'b1, 1'b0);
    load_a(2'd2, 8'd1, 8'd2, 8'd3);
    step(); a_if.load = 1'b0;
    exp_a("t4.w1", 1'b1, 8'd80, 1'b1, 1'b0);
`ifdef SERIALIZER_QUEUE_EN
    chk("t4.load_ready_pending", 32'(a_if.load_ready), 32'd0);
    step(); exp_a("t4.w2", 1'b1, 8'd90, 1'b1, 1'b0);
    step(); exp_a("t4.gap", 1'b0, 8'd0, 1'b1, 1'b1);
    step(); exp_a("t4.q0", 1'b1, 8'd1, 1'b1, 1'b0);
    chk("t4.load_ready_drained", 32'(a_if.load_ready), 32'd1);
    step(); exp_a("t4.q1", 1'b1, 8'd2, 1'b1, 1'b0);
    step(); exp_a("t4.qgap", 1'b0, 8'd0, 1'b1, 1'b1);
    step(); exp_a("t4.idle", 1'b0, 8'd0, 1'b0, 1'b0);
`else
    chk("t4.load_ready_busy", 32'(a_if.load_ready), 32'd0);
    step(); exp_a("t4.w2", 1'b1, 8'd90, 1'b1, 1'b0);
    step(); exp_a("t4.gap", 1'b0, 8'd0, 1'b1, 1'b1);
    step(); exp_a("t4.idle", 1'b0, 8'd0, 1'b0, 1'b0);
    step(); exp_a("t4.still_idle", 1'b0, 8'd0, 1'b0, 1'b0);
`endif

    // count=0 ignored, then a 3-word frame with a 4-cycle gap
    b_if.load = 1'b1; b_if.count = 2'd0; b_if.d0 = 8'd5;
    step();
    exp_b("t5.zero", 1'b0, 8'd0, 1'b0, 1'b0);
    chk("t5.zero.load_ready", 32'(b_if.load_ready), 32'd1);
    b_if.count = 2'd3; b_if.d0 = 8'd7; b_if.d1 = 8'd8; b_if.d2 = 8'd9;
    step(); b_if.load = 1'b0;
    exp_b("t5.w0", 1'b1, 8'd7, 1'b1, 1'b0);
    step(); exp_b("t5.w1", 1'b1, 8'd8, 1'b1, 1'b0);
    step(); exp_b("t5.w2", 1'b1, 8'd9, 1'b1, 1'b0);
    step(); exp_b("t5.gap1", 1'b0, 8'd0, 1'b1, 1'b1);
    step(); exp_b("t5.gap2", 1'b0, 8'd0, 1'b1, 1'b0);
    step(); exp_b("t5.gap3", 1'b0, 8'd0, 1'b1, 1'b0);
    step(); exp_b("t5.gap4", 1'b0, 8'd0, 1'b1, 1'b0);
    step(); exp_b("t5.idle", 1'b0, 8'd0, 1'b0, 1'b0);

    // asynchronous reset while value=50 is on the bus
    load_a(2'd3, 8'd40, 8'd50, 8'd60);
    step(); a_if.load = 1'b0;
    step();
    exp_a("t6.w1", 1'b1, 8'd50, 1'b1, 1'b0);
    #2 reset = 1'b1;
    #1 exp_a("t6.abort", 1'b0, 8'd0, 1'b0, 1'b0);
    reset = 1'b0;
    step();
    exp_a("t6.after", 1'b0, 8'd0, 1'b0, 1'b0);
    chk("t6.load_ready", 32'(a_if.load_ready), 32'd1);
    step();
    chk("t6.no_done", 32'(a_if.done), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
